// File: rtl/sha3_absorb_sequencer.sv
// sha3_absorb_sequencer: packs 32-bit message words into rate blocks,
// applies Keccak multi-rate padding, and hands blocks to f_permutation.
// Ports: clk, reset (sync, active-high); in/in_ready/is_last/byte_num from
// host; buffer_full stalls host; out/out_ready/f_ack toward f_permutation.
module sha3_absorb_sequencer #(
    parameter int RATE_WORDS = 18,
    parameter int WORD_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W-1:0]            in,
    input  logic                         in_ready,
    input  logic                         is_last,
    input  logic [1:0]                   byte_num,
    output logic                         buffer_full,
    output logic [RATE_WORDS*WORD_W-1:0] out,
    output logic                         out_ready,
    input  logic                         f_ack
);

    localparam int CW = $clog2(RATE_WORDS + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(RATE_WORDS - 1);

    typedef enum logic [1:0] {
        ABSORB,
        PAD,
        DONE_WAIT,
        DONE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   count, count_n;
    logic            full_n;
    logic            shift_en;
    logic            ack;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] pad_word;

    // DONE keeps the buffer marked full so the host stays stalled,
    // but the block is no longer offered to the permutation.
    assign out_ready = buffer_full && (state != DONE);
    assign ack       = out_ready && f_ack;

    always_comb begin
        pad_word = '0;
        unique case (byte_num)
            2'd0: pad_word = 32'h0100_0000;
            2'd1: pad_word = {in[31:24], 24'h01_0000};
            2'd2: pad_word = {in[31:16], 16'h0100};
            2'd3: pad_word = {in[31:8],  8'h01};
        endcase
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        full_n   = buffer_full;
        shift_en = 1'b0;
        word     = in;
        unique case (state)
            ABSORB: begin
                if (buffer_full) begin
                    if (ack) full_n = 1'b0;
                end else if (in_ready) begin
                    shift_en = 1'b1;
                    if (is_last) begin
                        // Pad byte and final 0x80 may share the last slot.
                        if (count == LAST_SLOT) begin
                            word    = pad_word | 32'h0000_0080;
                            state_n = DONE_WAIT;
                        end else begin
                            word    = pad_word;
                            state_n = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (!buffer_full) begin
                    shift_en = 1'b1;
                    if (count == LAST_SLOT) begin
                        word    = 32'h0000_0080;
                        state_n = DONE_WAIT;
                    end else begin
                        word = '0;
                    end
                end
            end
            DONE_WAIT: begin
                if (ack) state_n = DONE;
            end
            DONE: begin
                state_n = DONE;
            end
        endcase
        if (shift_en) begin
            if (count == LAST_SLOT) begin
                count_n = '0;
                full_n  = 1'b1;
            end else begin
                count_n = count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ABSORB;
            count       <= '0;
            buffer_full <= 1'b0;
            out         <= '0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            buffer_full <= full_n;
            if (shift_en)
                out <= {out[RATE_WORDS*WORD_W-WORD_W-1:0], word};
        end
    end

endmodule
